// File: rtl/flag_unit_pkg.sv
// Shared opcode constants, flag bit positions and flag-mask type for the flag unit.
package flag_unit_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef logic [2:0] flag_mask_t;

  localparam flag_mask_t MASK_NONE = 3'b000;
  localparam flag_mask_t MASK_Z    = 3'b100;
  localparam flag_mask_t MASK_ALL  = 3'b111;

endpackage

// File: rtl/flag_mask_decode.sv
// Combinational opcode -> flag update mask ({Z,V,N}); unknown opcodes write nothing.
module flag_mask_decode
  import flag_unit_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] i_opcode,
  output flag_mask_t     o_mask
);

  always_comb begin
    o_mask = MASK_NONE;
    case (i_opcode)
      OPW'(OP_ADD), OPW'(OP_SUB):                         o_mask = MASK_ALL;
      OPW'(OP_XOR), OPW'(OP_SLL), OPW'(OP_SRA), OPW'(OP_ROR): o_mask = MASK_Z;
      default:                                            o_mask = MASK_NONE;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag producer: one-entry pending stage feeding the committed {Z,V,N} register.
// Optional macro FLAG_BYPASS_EN overlays pending flags onto the bus instead of raising flag_hazard.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int         OPW      = 4,
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  logic [OPW-1:0] ex_opcode,
  input  logic           alu_z,
  input  logic           alu_v,
  input  logic           alu_n,
  input  logic           stall,
  input  logic           flush,
  output logic [2:0]     flags,
  output logic           flag_hazard
);

  flag_mask_t w_mask;
  logic [2:0] w_alu;
  logic       w_capture;

  logic [2:0] r_commit;
  logic       r_pend_valid;
  flag_mask_t r_pend_mask;
  logic [2:0] r_pend_val;

  flag_mask_decode #(.OPW(OPW)) u_decode (
    .i_opcode (ex_opcode),
    .o_mask   (w_mask)
  );

  always_comb begin
    w_alu         = 3'b000;
    w_alu[FLAG_Z] = alu_z;
    w_alu[FLAG_V] = alu_v;
    w_alu[FLAG_N] = alu_n;
  end

  assign w_capture = ex_valid & (w_mask != MASK_NONE) & ~stall & ~flush;

  // Flush beats stall; commit always uses the pending contents from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit     <= FLAG_RST;
      r_pend_valid <= 1'b0;
      r_pend_mask  <= MASK_NONE;
      r_pend_val   <= 3'b000;
    end else if (flush) begin
      r_pend_valid <= 1'b0;
    end else if (!stall) begin
      if (r_pend_valid) begin
        r_commit <= (r_commit & ~r_pend_mask) | (r_pend_val & r_pend_mask);
      end
      r_pend_valid <= w_capture;
      if (w_capture) begin
        r_pend_mask <= w_mask;
        r_pend_val  <= w_alu;
      end
    end
  end

`ifdef FLAG_BYPASS_EN
  assign flags       = r_pend_valid ? ((r_commit & ~r_pend_mask) | (r_pend_val & r_pend_mask))
                                    : r_commit;
  assign flag_hazard = 1'b0;
`else
  assign flags       = r_commit;
  assign flag_hazard = r_pend_valid & ~flush;
`endif

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit; expectations follow FLAG_BYPASS_EN if defined.
module tb_flag_unit;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_NOP = 4'b0011;

`ifdef FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic       alu_z, alu_v, alu_n;
  logic       stall, flush;
  logic [2:0] flags;
  logic       flag_hazard;

  int total = 0;
  int bad   = 0;

  flag_unit #(.OPW(4), .FLAG_RST(3'b000)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .alu_z       (alu_z),
    .alu_v       (alu_v),
    .alu_n       (alu_n),
    .stall       (stall),
    .flush       (flush),
    .flags       (flags),
    .flag_hazard (flag_hazard)
  );

  always #5 clk = ~clk;

  task automatic setIdle();
    ex_valid  = 1'b0;
    ex_opcode = OP_NOP;
    alu_z     = 1'b0;
    alu_v     = 1'b0;
    alu_n     = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
  endtask

  // Drive one cycle of inputs, take the edge, then return inputs to idle before checking.
  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic z, input logic ov,
                               input logic n, input logic st, input logic fl);
    ex_valid  = v;
    ex_opcode = op;
    alu_z     = z;
    alu_v     = ov;
    alu_n     = n;
    stall     = st;
    flush     = fl;
    @(posedge clk);
    #1;
    setIdle();
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] expNoByp, input logic expHaz,
                             input logic [2:0] expByp);
    logic [2:0] expFlags;
    logic       expH;
    expFlags = BYP ? expByp : expNoByp;
    expH     = BYP ? 1'b0 : expHaz;
    total++;
    assert (flags === expFlags) else begin
      bad++;
      $error("[TB] FAIL %s flags: got %b want %b", tag, flags, expFlags);
    end
    total++;
    assert (flag_hazard === expH) else begin
      bad++;
      $error("[TB] FAIL %s hazard: got %b want %b", tag, flag_hazard, expH);
    end
  endtask

  initial begin
    setIdle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset", 3'b000, 1'b0, 3'b000);

    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 0, 0);
    checkOutput("idle", 3'b000, 1'b0, 3'b000);

    applyStimulus(1'b1, OP_ADD, 0, 1, 1, 0, 0);
    checkOutput("add_pending", 3'b000, 1'b1, 3'b011);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 0, 0);
    checkOutput("add_commit", 3'b011, 1'b0, 3'b011);

    applyStimulus(1'b1, OP_XOR, 1, 0, 0, 0, 0);
    checkOutput("xor_pending", 3'b011, 1'b1, 3'b111);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 0, 0);
    checkOutput("xor_commit", 3'b111, 1'b0, 3'b111);

    applyStimulus(1'b1, OP_SUB, 0, 0, 0, 0, 0);
    checkOutput("sub_pending", 3'b111, 1'b1, 3'b000);
    flush = 1'b1;
    #1;
    checkOutput("flush_cycle", 3'b111, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    setIdle();
    checkOutput("after_flush", 3'b111, 1'b0, 3'b111);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 0, 0);
    checkOutput("no_commit_flushed", 3'b111, 1'b0, 3'b111);

    applyStimulus(1'b1, OP_SUB, 0, 1, 0, 0, 0);
    checkOutput("sub2_pending", 3'b111, 1'b1, 3'b010);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 1, 0);
    checkOutput("stall1", 3'b111, 1'b1, 3'b010);
    applyStimulus(1'b1, OP_ADD, 1, 1, 1, 1, 0);
    checkOutput("stall2_no_capture", 3'b111, 1'b1, 3'b010);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 1, 0);
    checkOutput("stall3", 3'b111, 1'b1, 3'b010);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 0, 0);
    checkOutput("stall_release_commit", 3'b010, 1'b0, 3'b010);

    applyStimulus(1'b1, OP_ADD, 1, 0, 0, 0, 0);
    checkOutput("b2b_add", 3'b010, 1'b1, 3'b100);
    applyStimulus(1'b1, OP_SLL, 0, 1, 1, 0, 0);
    checkOutput("b2b_sll", 3'b100, 1'b1, 3'b000);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 0, 0);
    checkOutput("b2b_final", 3'b000, 1'b0, 3'b000);

    applyStimulus(1'b1, OP_NOP, 1, 1, 1, 0, 0);
    checkOutput("nonwriter_op", 3'b000, 1'b0, 3'b000);
    applyStimulus(1'b0, OP_ADD, 1, 1, 1, 0, 0);
    checkOutput("bubble_add", 3'b000, 1'b0, 3'b000);
    applyStimulus(1'b1, OP_ADD, 1, 1, 1, 0, 1);
    checkOutput("flush_blocks_capture", 3'b000, 1'b0, 3'b000);

    applyStimulus(1'b1, OP_ADD, 1, 1, 1, 0, 0);
    checkOutput("pre_stall_flush", 3'b000, 1'b1, 3'b111);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 1, 1);
    checkOutput("flush_over_stall", 3'b000, 1'b0, 3'b000);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 0, 0);
    checkOutput("flush_over_stall_hold", 3'b000, 1'b0, 3'b000);

    applyStimulus(1'b1, OP_ROR, 1, 1, 1, 0, 0);
    applyStimulus(1'b0, OP_NOP, 0, 0, 0, 0, 0);
    checkOutput("ror_commit", 3'b100, 1'b0, 3'b100);
    rst = 1'b1;
    applyStimulus(1'b1, OP_ADD, 0, 1, 1, 0, 0);
    rst = 1'b0;
    checkOutput("mid_reset", 3'b000, 1'b0, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
